// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, FFT base address and arbiter state encoding
package wb_pkg;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam logic [31:0] WB_FFT_BASE = 32'h1003_0000;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;
endpackage

// File: rtl/fft_wb_arbiter_if.sv
// fft_wb_arbiter_if: classic Wishbone bus bundle with master and slave views
interface fft_wb_arbiter_if #(parameter int AW = 32);
  import wb_pkg::*;
  logic cyc;
  logic stb;
  logic we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [SW-1:0] sel;
  logic [DW-1:0] dat_r;
  logic ack;
  logic err;
  modport master(output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
  modport slave(input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface

// File: rtl/wb_watchdog.sv
// wb_watchdog: counts unacknowledged strobe cycles and flags expiry at TIMEOUT-1
module wb_watchdog #(parameter int TIMEOUT = 255) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic stb,
  input  logic ack,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] wd_cnt;
  // an ack on the limit cycle suppresses expiry
  assign expired = en & stb & ~ack & (wd_cnt == W'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) wd_cnt <= '0;
    else wd_cnt <= (!en || !stb || ack || expired) ? '0 : wd_cnt + 1'b1;
endmodule

// File: rtl/fft_wb_arbiter.sv
// fft_wb_arbiter: round-robin two-master Wishbone arbiter in front of the FFT core
module fft_wb_arbiter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW = 32
) (
  input  logic clk,
  input  logic rst,
  fft_wb_arbiter_if.slave  m0,
  fft_wb_arbiter_if.slave  m1,
  fft_wb_arbiter_if.master s,
  output logic [1:0] grant
);
  logic [1:0] st, st_nx;
  logic last;
  logic own0, own1, in_err, expired;
  logic [AW-1:0] adr_mux;
  assign own0 = st == ST_OWN0;
  assign own1 = st == ST_OWN1;
  assign in_err = st == ST_ERR;
  assign grant = {own1, own0};
  // tie goes to whichever master did not win the previous grant
  always_comb begin
    st_nx = st;
    case (st)
      ST_IDLE: st_nx = (m0.cyc && (!m1.cyc || last)) ? ST_OWN0 : m1.cyc ? ST_OWN1 : ST_IDLE;
      ST_OWN0: st_nx = !m0.cyc ? ST_IDLE : expired ? ST_ERR : ST_OWN0;
      ST_OWN1: st_nx = !m1.cyc ? ST_IDLE : expired ? ST_ERR : ST_OWN1;
      default: st_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ST_IDLE;
      last <= 1'b1;
    end else begin
      st <= st_nx;
      last <= (st_nx == ST_OWN0) ? 1'b0 : (st_nx == ST_OWN1) ? 1'b1 : last;
    end
  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst(rst),
    .en(own0 | own1),
    .stb(s.stb),
    .ack(s.ack),
    .expired(expired)
  );
  assign adr_mux = own0 ? m0.adr : own1 ? m1.adr : '0;
  assign s.adr = adr_mux;
  assign s.cyc = own0 ? m0.cyc : own1 & m1.cyc;
  assign s.stb = own0 ? m0.stb : own1 & m1.stb;
  assign s.we = own0 ? m0.we : own1 & m1.we;
  assign s.dat_w = own0 ? m0.dat_w : own1 ? m1.dat_w : '0;
  assign s.sel = own0 ? m0.sel : own1 ? m1.sel : '0;
  assign m0.ack = own0 & s.ack & m0.stb;
  assign m1.ack = own1 & s.ack & m1.stb;
  assign m0.dat_r = own0 ? s.dat_r : '0;
  assign m1.dat_r = own1 ? s.dat_r : '0;
  // last always names the master whose transfer timed out
  assign m0.err = in_err & ~last;
  assign m1.err = in_err & last;
endmodule

// File: tb/tb_fft_wb_arbiter.sv
// tb_fft_wb_arbiter: directed stimulus with per-master response scoreboards
module tb_fft_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] grant;
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int ack_dly = 1;
  int scnt = 0;
  bit m1_done = 0;
  logic [33:0] q0[$];
  logic [33:0] q1[$];

  fft_wb_arbiter_if #(.AW(32)) m0();
  fft_wb_arbiter_if #(.AW(32)) m1();
  fft_wb_arbiter_if #(.AW(32)) s();

  fft_wb_arbiter #(.TIMEOUT(16), .AW(32)) dut (
    .clk(clk),
    .rst(rst),
    .m0(m0),
    .m1(m1),
    .s(s),
    .grant(grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // slave: acks ack_dly cycles after it first sees a strobe (0 = never)
  assign s.err = 1'b0;
  assign s.dat_r = s.ack ? {s.adr[15:0], 16'hBEEF} : 32'h0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      s.ack <= 1'b0;
      scnt <= 0;
    end else if (!(s.cyc && s.stb) || s.ack) begin
      s.ack <= 1'b0;
      scnt <= 0;
    end else if (ack_dly > 0 && scnt == ack_dly - 1) s.ack <= 1'b1;
    else scnt <= scnt + 1;

  function automatic logic [33:0] rd_ok(input logic [31:0] a);
    return {2'b10, a[15:0], 16'hBEEF};
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (m0.ack || m0.err) begin
        if (q0.size() == 0) chk("m0_unexpected", {m0.ack, m0.err}, 0);
        else chk("m0_resp", {m0.ack, m0.err, m0.dat_r}, q0.pop_front());
        if (m0.ack) chk("m0_ack_coinc", s.ack, 1);
      end else chk("m0_dat_quiet", m0.dat_r, 0);
      if (m1.ack || m1.err) begin
        if (q1.size() == 0) chk("m1_unexpected", {m1.ack, m1.err}, 0);
        else chk("m1_resp", {m1.ack, m1.err, m1.dat_r}, q1.pop_front());
        if (m1.ack) chk("m1_ack_coinc", s.ack, 1);
      end else chk("m1_dat_quiet", m1.dat_r, 0);
    end

  task automatic setm(input int m, input logic c, input logic st, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0.cyc = c; m0.stb = st; m0.we = w; m0.adr = a; m0.dat_w = d; m0.sel = w ? 4'h3 : 4'hf;
    end else begin
      m1.cyc = c; m1.stb = st; m1.we = w; m1.adr = a; m1.dat_w = d; m1.sel = w ? 4'h3 : 4'hf;
    end
  endtask

  function automatic bit got(input int m);
    return m == 0 ? (m0.ack | m0.err) : (m1.ack | m1.err);
  endfunction

  task automatic xfer(input int m, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input bit keep);
    setm(m, 1, 1, w, a, d);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (got(m)) break;
      if (n == 100) begin
        chk("xfer_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    setm(m, keep, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic tie(input logic [31:0] a0, input logic [31:0] a1);
    q0.push_back(rd_ok(a0));
    q1.push_back(rd_ok(a1));
    fork
      xfer(0, a0, 0, 0, 0);
      xfer(1, a1, 0, 0, 0);
      begin
        @(negedge clk);
        chk("tie_idle", grant, 0);
        @(negedge clk);
        chk("tie_first_m0", grant, 1);
        for (int n = 0; n < 50 && grant == 2'b01; n++) @(negedge clk);
        chk("tie_bubble", grant, 0);
        @(negedge clk);
        chk("tie_second_m1", grant, 2);
      end
    join
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    setm(0, 0, 0, 0, 0, 0);
    setm(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_s_cyc", s.cyc, 0);
    chk("rst_s_stb", s.stb, 0);
    chk("rst_s_adr", s.adr, 0);
    chk("rst_m_ack_err", {m0.ack, m0.err, m1.ack, m1.err}, 0);
    chk("rst_m_dat", {m0.dat_r, m1.dat_r}, 0);
    step;
    rst = 1'b0;
    step;
    ack_dly = 2;
    tie(32'h1003_0010, 32'h1003_0020);
    step;
    tie(32'h1003_0030, 32'h1003_0034);
    step;
    ack_dly = 3;
    q0.push_back(34'h2_1004_BEEF);
    fork
      xfer(0, 32'h1003_1004, 0, 0, 0);
      begin
        @(negedge clk);
        chk("single_s_cyc_pre", s.cyc, 0);
        @(negedge clk);
        chk("single_s_cyc", s.cyc, 1);
        chk("single_grant", grant, 1);
        chk("single_s_adr", s.adr, 32'h1003_1004);
      end
    join
    step;
    ack_dly = 1;
    for (int i = 0; i < 8; i++) q1.push_back(rd_ok(32'h1003_2000 + 4 * i));
    q0.push_back(rd_ok(32'h1003_0080));
    m1_done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) xfer(1, 32'h1003_2000 + 4 * i, 0, 0, i < 7);
        m1_done = 1;
      end
      begin
        repeat (2) step;
        xfer(0, 32'h1003_0080, 0, 0, 0);
        chk("burst_lock", m1_done, 1);
      end
    join
    step;
    ack_dly = 2;
    q1.push_back(rd_ok(32'h1003_0100));
    fork
      xfer(1, 32'h1003_0100, 1, 32'hCAFE_F00D, 0);
      begin
        repeat (2) @(negedge clk);
        chk("wr_grant", grant, 2);
        chk("wr_s_we", s.we, 1);
        chk("wr_s_dat_w", s.dat_w, 32'hCAFE_F00D);
        chk("wr_s_sel", s.sel, 4'h3);
      end
    join
    step;
    ack_dly = 0;
    q0.push_back(34'h1_0000_0000);
    fork
      xfer(0, 32'h1003_0040, 0, 0, 0);
      begin
        int t0, t1;
        t0 = 0;
        t1 = 0;
        for (int n = 0; n < 50 && !s.stb; n++) @(negedge clk);
        t0 = cyc_n;
        for (int n = 0; n < 50 && !m0.err; n++) @(negedge clk);
        t1 = cyc_n;
        chk("to_latency", t1 - t0, 16);
        chk("to_err", m0.err, 1);
        chk("to_s_cyc", s.cyc, 0);
        chk("to_grant", grant, 0);
        @(negedge clk);
        chk("to_err_pulse", m0.err, 0);
        chk("to_idle", grant, 0);
      end
    join
    step;
    ack_dly = 15;
    q0.push_back(rd_ok(32'h1003_0044));
    fork
      xfer(0, 32'h1003_0044, 0, 0, 0);
      begin
        int ec;
        ec = 0;
        repeat (20) begin
          @(negedge clk);
          if (m0.err) ec++;
        end
        chk("limit_no_err", ec, 0);
      end
    join
    step;
    ack_dly = 0;
    setm(1, 1, 1, 0, 32'h1003_2000, 0);
    for (int n = 0; n < 5 && grant != 2'b10; n++) @(negedge clk);
    chk("arst_pre_grant", grant, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_s", {s.cyc, s.stb, s.we}, 0);
    chk("arst_s_adr", s.adr, 0);
    chk("arst_m", {m0.ack, m0.err, m1.ack, m1.err}, 0);
    setm(1, 0, 0, 0, 0, 0);
    repeat (2) step;
    rst = 1'b0;
    step;
    ack_dly = 2;
    tie(32'h1003_0050, 32'h1003_0054);
    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
